gw2a_ddr_rdlvl_ctrl: RTL and testbench

GW2A_DDR_RDLVL_CTRL -- requirements
Module: gw2a_ddr_rdlvl_ctrl

---
 rtl/gw2a_ddr_rdlvl_ctrl.sv | 175 +++++++++++++++++
 tb/tb_gw2a_ddr_rdlvl_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gw2a_ddr_rdlvl_ctrl.sv
// DDR read-leveling sweep: tries every IOB SHIFT on all byte lanes against a known pattern
// and settles each lane on its lowest passing shift.
// States: IDLE wait start | SETTLE let shift settle | REQ/WAIT read burst | CHECK compare | NEXT record/advance | DONE pick result
module gw2a_ddr_rdlvl_ctrl #(
  parameter int          LANES   = 2,
  parameter logic [15:0] PATTERN = 16'hA55A,
  parameter int          SETTLE  = 4,
  parameter int          TRIES   = 2,
  parameter int          TIMEOUT = 63
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [2*LANES-1:0]    shift_o,
  output logic [4*LANES-1:0]    pass_o,
  output logic                  rd_req_o,
  input  logic                  rd_ack_i,
  input  logic                  rd_valid_i,
  input  logic [16*LANES-1:0]   rd_data_i
);

  localparam int SETTLE_LD = (SETTLE > 1) ? SETTLE - 1 : 0;
  localparam int TMO_LD    = (TIMEOUT > 1) ? TIMEOUT - 1 : 0;
  localparam int CNT_MAX   = (SETTLE_LD > TMO_LD) ? SETTLE_LD : TMO_LD;
  localparam int CW        = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int TRY_LAST  = (TRIES > 1) ? TRIES - 1 : 0;
  localparam int TW        = (TRY_LAST < 1) ? 1 : $clog2(TRY_LAST + 1);

  localparam logic [CW-1:0] C_SETTLE = CW'(SETTLE_LD);
  localparam logic [CW-1:0] C_TMO    = CW'(TMO_LD);
  localparam logic [TW-1:0] C_TRY    = TW'(TRY_LAST);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_REQ, S_WAIT, S_CHECK, S_NEXT, S_DONE
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [TW-1:0]         r_try;
  logic [1:0]            r_sweep;
  logic [LANES-1:0]      r_cand;
  logic [16*LANES-1:0]   r_data;
  logic                  r_tmo;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_fail;
  logic [2*LANES-1:0]    r_shift;
  logic [4*LANES-1:0]    r_pass;
  logic                  r_rd_req;

  logic [LANES-1:0]      w_match;
  logic [LANES-1:0]      w_empty;
  logic [2*LANES-1:0]    w_pick;

  // A timed-out read carries stale data, so it never matches.
  always_comb begin
    w_match = '0;
    w_empty = '0;
    w_pick  = '0;
    for (int n = 0; n < LANES; n++) begin
      w_match[n] = !r_tmo && (r_data[16*n +: 16] == PATTERN);
      w_empty[n] = (r_pass[4*n +: 4] == 4'd0);
      for (int b = 3; b >= 0; b--) begin
        if (r_pass[4*n + b]) w_pick[2*n +: 2] = 2'(b);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_try    <= '0;
      r_sweep  <= '0;
      r_cand   <= '0;
      r_data   <= '0;
      r_tmo    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_fail   <= 1'b0;
      r_shift  <= '0;
      r_pass   <= '0;
      r_rd_req <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            r_pass  <= '0;
            r_sweep <= 2'd0;
            r_shift <= '0;
            r_try   <= '0;
            r_cand  <= '1;
            r_cnt   <= C_SETTLE;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_rd_req <= 1'b1;
            r_state  <= S_REQ;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_REQ: begin
          if (rd_ack_i) begin
            r_rd_req <= 1'b0;
            r_cnt    <= C_TMO;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Valid wins over an expiry in the same cycle.
          if (rd_valid_i) begin
            r_data  <= rd_data_i;
            r_tmo   <= 1'b0;
            r_state <= S_CHECK;
          end else if (r_cnt == '0) begin
            r_tmo   <= 1'b1;
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CHECK: begin
          r_cand <= r_cand & w_match;
          if (r_try == C_TRY) begin
            r_state <= S_NEXT;
          end else begin
            r_try    <= r_try + 1'b1;
            r_rd_req <= 1'b1;
            r_state  <= S_REQ;
          end
        end
        S_NEXT: begin
          for (int n = 0; n < LANES; n++) begin
            r_pass[4*n +: 4] <= r_pass[4*n +: 4] | ({3'b000, r_cand[n]} << r_sweep);
          end
          if (r_sweep == 2'd3) begin
            r_state <= S_DONE;
          end else begin
            r_sweep <= r_sweep + 2'd1;
            r_shift <= {LANES{r_sweep + 2'd1}};
            r_try   <= '0;
            r_cand  <= '1;
            r_cnt   <= C_SETTLE;
            r_state <= S_SETTLE;
          end
        end
        S_DONE: begin
          r_shift <= w_pick;
          r_fail  <= |w_empty;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign fail_o   = r_fail;
  assign shift_o  = r_shift;
  assign pass_o   = r_pass;
  assign rd_req_o = r_rd_req;

endmodule

// File: tb/tb_gw2a_ddr_rdlvl_ctrl.sv
// Directed bench for the read-leveling controller: a read responder driven from a
// per-lane match table plus handshake-timing statistics gathered on the falling edge.
module tb_gw2a_ddr_rdlvl_ctrl;
  localparam int          LANES = 2;
  localparam logic [15:0] PAT   = 16'hA55A;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 start_i = 1'b0;
  logic                 busy_o, done_o, fail_o, rd_req_o;
  logic [2*LANES-1:0]   shift_o;
  logic [4*LANES-1:0]   pass_o;
  logic                 rd_ack_i;
  logic                 rd_valid_i;
  logic [16*LANES-1:0]  rd_data_i;

  gw2a_ddr_rdlvl_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .fail_o     (fail_o),
    .shift_o    (shift_o),
    .pass_o     (pass_o),
    .rd_req_o   (rd_req_o),
    .rd_ack_i   (rd_ack_i),
    .rd_valid_i (rd_valid_i),
    .rd_data_i  (rd_data_i)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // responder configuration, changed by the main sequence only while idle
  logic [3:0] ok_l0 = 4'hF;
  logic [3:0] ok_l1 = 4'hF;
  logic [7:0] kill_l0 = 8'h00;
  logic [7:0] kill_l1 = 8'h00;
  int         ack_delay = 1;
  int         valid_delay = 2;
  bit         no_valid = 1'b0;

  // per-sweep statistics, cleared when busy_o rises
  int acks, valids, rises, run, run_min, run_max, low, low_min, lat;
  bit lat_on, prev_busy, prev_req;

  initial begin
    int phase, reqcnt, vcnt, cur_idx;
    logic [1:0] sh;
    bit ok;
    rd_ack_i = 1'b0; rd_valid_i = 1'b0; rd_data_i = '0;
    phase = 0; reqcnt = 0; vcnt = 0; cur_idx = 0;
    acks = 0; valids = 0; rises = 0; run = 0; run_min = 1000; run_max = 0;
    low = 0; low_min = 1000; lat = 0; lat_on = 1'b0; prev_busy = 1'b0; prev_req = 1'b0;
    forever begin
      @(negedge clock);
      rd_ack_i   = 1'b0;
      rd_valid_i = 1'b0;
      if (reset) begin
        phase = 0; reqcnt = 0; prev_busy = 1'b0; prev_req = 1'b0; lat_on = 1'b0;
      end else begin
        if (busy_o && !prev_busy) begin
          acks = 0; valids = 0; rises = 0; run = 0; run_min = 1000; run_max = 0;
          low = 0; low_min = 1000; lat = 0; lat_on = 1'b1;
        end else if (lat_on) begin
          lat++;
          if (rd_req_o) lat_on = 1'b0;
        end
        prev_busy = busy_o;
        if (rd_req_o) begin
          if (!prev_req) begin
            rises++;
            if (rises > 1 && low < low_min) low_min = low;
          end
          run++;
          low = 0;
        end else begin
          if (prev_req) begin
            if (run < run_min) run_min = run;
            if (run > run_max) run_max = run;
          end
          run = 0;
          low++;
        end
        prev_req = rd_req_o;
        if (phase == 0) begin
          if (rd_req_o) begin
            reqcnt++;
            if (reqcnt >= ack_delay) begin
              rd_ack_i = 1'b1;
              cur_idx  = acks;
              acks++;
              reqcnt = 0;
              vcnt   = 0;
              phase  = no_valid ? 0 : 1;
            end
          end
        end else begin
          vcnt++;
          if (vcnt >= valid_delay) begin
            for (int n = 0; n < LANES; n++) begin
              sh = shift_o[2*n +: 2];
              if (n == 0) ok = ok_l0[sh] && !kill_l0[cur_idx[2:0]];
              else        ok = ok_l1[sh] && !kill_l1[cur_idx[2:0]];
              rd_data_i[16*n +: 16] = ok ? PAT : (PAT ^ 16'h0100);
            end
            rd_valid_i = 1'b1;
            valids++;
            phase = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_sweep(input string tag);
    @(negedge clock);
    start_i = 1'b1;
    @(negedge clock);
    start_i = 1'b0;
    chk({tag, "_acc_busy"}, 32'(busy_o), 32'd1);
    chk({tag, "_acc_done"}, 32'(done_o), 32'd0);
    chk({tag, "_acc_pass"}, 32'(pass_o), 32'd0);
  endtask

  task automatic finish_sweep(input string tag, input logic [7:0] e_pass,
                              input logic [3:0] e_shift, input logic e_fail);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_done"},  32'(done_o),  32'd1);
    chk({tag, "_busy"},  32'(busy_o),  32'd0);
    chk({tag, "_pass"},  32'(pass_o),  32'(e_pass));
    chk({tag, "_shift"}, 32'(shift_o), 32'(e_shift));
    chk({tag, "_fail"},  32'(fail_o),  32'(e_fail));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    chk("rst_busy",  32'(busy_o),   32'd0);
    chk("rst_done",  32'(done_o),   32'd0);
    chk("rst_fail",  32'(fail_o),   32'd0);
    chk("rst_req",   32'(rd_req_o), 32'd0);
    chk("rst_shift", 32'(shift_o),  32'd0);
    chk("rst_pass",  32'(pass_o),   32'd0);

    // lane 0 only at shift 2, lane 1 only at shift 1
    ok_l0 = 4'b0100; ok_l1 = 4'b0010;
    start_sweep("t1");
    finish_sweep("t1", 8'h24, 4'b0110, 1'b0);
    chk("t1_settle_lat", 32'(lat), 32'd4);
    chk("t1_req_run", 32'(run_max), 32'd1);
    chk("t1_acks", 32'(acks), 32'd8);

    // stray start mid-sweep must not restart it
    ok_l0 = 4'b1110; ok_l1 = 4'b1111;
    start_sweep("t2");
    repeat (20) @(negedge clock);
    start_i = 1'b1;
    @(negedge clock);
    start_i = 1'b0;
    finish_sweep("t2", 8'hFE, 4'b0001, 1'b0);
    chk("t2_acks", 32'(acks), 32'd8);

    ok_l0 = 4'b1000; ok_l1 = 4'b0000;
    start_sweep("t3");
    finish_sweep("t3", 8'h08, 4'b0011, 1'b1);

    // lane 0 second read at shift 0 mismatches
    ok_l0 = 4'hF; ok_l1 = 4'hF; kill_l0 = 8'b0000_0010;
    start_sweep("t4");
    finish_sweep("t4", 8'hFE, 4'b0001, 1'b0);
    kill_l0 = 8'h00;

    ack_delay = 5;
    start_sweep("t5");
    finish_sweep("t5", 8'hFF, 4'b0000, 1'b0);
    chk("t5_run_min", 32'(run_min), 32'd5);
    chk("t5_run_max", 32'(run_max), 32'd5);
    chk("t5_acks",    32'(acks),    32'd8);
    chk("t5_rises",   32'(rises),   32'd8);
    chk("t5_valids",  32'(valids),  32'd8);
    ack_delay = 1;

    // every read times out: 63 WAIT cycles plus CHECK between requests
    no_valid = 1'b1;
    start_sweep("t6");
    finish_sweep("t6", 8'h00, 4'b0000, 1'b1);
    chk("t6_acks",    32'(acks),    32'd8);
    chk("t6_valids",  32'(valids),  32'd0);
    chk("t6_low_gap", 32'(low_min), 32'd64);
    no_valid = 1'b0;

    valid_delay = 63;
    start_sweep("t7a");
    finish_sweep("t7a", 8'hFF, 4'b0000, 1'b0);
    valid_delay = 64;
    start_sweep("t7b");
    finish_sweep("t7b", 8'h00, 4'b0000, 1'b1);
    valid_delay = 2;

    // reset in WAIT of shift 2
    valid_delay = 20;
    start_sweep("t8");
    n = 0;
    while (!(shift_o == 4'b1010 && rd_req_o) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("t8_reach", 32'(shift_o), 32'b1010);
    n = 0;
    while (rd_req_o && n < 50) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    chk("t8_mid_pass", 32'(pass_o), 32'h33);
    chk("t8_mid_busy", 32'(busy_o), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t8_rst_busy",  32'(busy_o),   32'd0);
    chk("t8_rst_done",  32'(done_o),   32'd0);
    chk("t8_rst_fail",  32'(fail_o),   32'd0);
    chk("t8_rst_req",   32'(rd_req_o), 32'd0);
    chk("t8_rst_shift", 32'(shift_o),  32'd0);
    chk("t8_rst_pass",  32'(pass_o),   32'd0);
    @(negedge clock);
    valid_delay = 2;
    #2 reset = 1'b0;
    start_i = 1'b1;
    @(negedge clock);
    start_i = 1'b0;
    chk("t8_first_edge", 32'(busy_o), 32'd1);
    finish_sweep("t8r", 8'hFF, 4'b0000, 1'b0);
    chk("t8r_acks", 32'(acks), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
